ir_tx_module: RTL

NEC-format infrared transmitter, the transmit counterpart of the board's IR receive path. Accepts an 8-bit address and 8-bit command (or a repeat request) through a start/busy/done handshake. Generates the NEC pulse-distance envelope and modulates it onto a 38 kHz, 1/3-duty carrier to drive the IR LED. Runs directly from the 48 MHz board clock; all timing is derived internally from a 1 µs tick.

---
 rtl/ir_tx_module_if.sv | 14 +
 rtl/ir_tx_module.sv | 112 +++++++++++
 2 files changed

// File: rtl/ir_tx_module_if.sv
// Start/busy/done request channel of the NEC IR transmitter.
// The caller drives the master side; the transmitter is the slave.
`timescale 1ns/1ps
interface ir_tx_module_if;
    logic       start;
    logic       rep;
    logic [7:0] addr;
    logic [7:0] cmd;
    logic       busy;
    logic       done;

    modport master (output start, rep, addr, cmd, input busy, done);
    modport slave  (input start, rep, addr, cmd, output busy, done);
endinterface

// File: rtl/ir_tx_module.sv
// NEC-format IR transmitter: pulse-distance envelope on a 1 us tick, modulated
// onto a 1/3-duty carrier that restarts high at the beginning of every mark.
`timescale 1ns/1ps
module ir_tx_module #(
    parameter int unsigned CLK_HZ     = 48_000_000,
    parameter int unsigned CARRIER_HZ = 38_000
) (
    input  logic          clk,
    input  logic          rst_n,
    ir_tx_module_if.slave bus,
    output logic          ir_env,
    output logic          ir_out
);
    localparam int unsigned TICK_DIV = CLK_HZ / 1_000_000;
    localparam int unsigned CAR_PER  = CLK_HZ / CARRIER_HZ;
    localparam int unsigned CAR_HIGH = CAR_PER / 3;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CAR_W    = (CAR_PER > 1) ? $clog2(CAR_PER) : 1;

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, REP_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
    } state_t;

    state_t           r_state, w_next;
    logic [PRE_W-1:0] r_pre;
    logic [13:0]      r_cnt;
    logic [4:0]       r_bit;
    logic [31:0]      r_sr;
    logic [CAR_W-1:0] r_car;
    logic             r_rep, r_busy, r_done, r_env, r_out;
    logic             w_accept, w_tick, w_end, w_mark, w_next_mark;
    logic [13:0]      w_dur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // A start is refused until both busy and the trailing done pulse have cleared.
        w_accept = bus.start && (r_state == IDLE) && !r_busy && !r_done;
        w_tick   = (r_pre == PRE_W'(TICK_DIV - 1));
        w_dur    = '0;
        case (r_state)
            LEAD_MARK:           w_dur = 14'd9000;
            LEAD_SPACE:          w_dur = 14'd4500;
            REP_SPACE:           w_dur = 14'd2250;
            BIT_MARK, STOP_MARK: w_dur = 14'd560;
            BIT_SPACE:           w_dur = r_sr[0] ? 14'd1690 : 14'd560;
            default:             w_dur = '0;
        endcase
        w_end  = (r_state != IDLE) && w_tick && (r_cnt == w_dur - 14'd1);
        w_next = r_state;
        case (r_state)
            IDLE:       if (w_accept) w_next = LEAD_MARK;
            LEAD_MARK:  if (w_end) w_next = r_rep ? REP_SPACE : LEAD_SPACE;
            LEAD_SPACE: if (w_end) w_next = BIT_MARK;
            REP_SPACE:  if (w_end) w_next = STOP_MARK;
            BIT_MARK:   if (w_end) w_next = BIT_SPACE;
            BIT_SPACE:  if (w_end) w_next = (r_bit == 5'd31) ? STOP_MARK : BIT_MARK;
            STOP_MARK:  if (w_end) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
        w_mark      = (r_state == LEAD_MARK) || (r_state == BIT_MARK) || (r_state == STOP_MARK);
        w_next_mark = (w_next == LEAD_MARK) || (w_next == BIT_MARK) || (w_next == STOP_MARK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_cnt  <= '0;
            r_bit  <= '0;
            r_sr   <= '0;
            r_car  <= '0;
            r_rep  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_env  <= 1'b0;
            r_out  <= 1'b0;
        end else begin
            r_pre <= (w_accept || w_tick) ? '0 : r_pre + 1'b1;
            if (w_accept) begin
                r_rep <= bus.rep;
                r_sr  <= {~bus.cmd, bus.cmd, ~bus.addr, bus.addr};
                r_cnt <= '0;
                r_bit <= '0;
            end else if (w_end) begin
                r_cnt <= '0;
                if (r_state == BIT_SPACE) begin
                    r_sr  <= r_sr >> 1;
                    r_bit <= r_bit + 5'd1;
                end
            end else if (w_tick && (r_state != IDLE)) begin
                r_cnt <= r_cnt + 14'd1;
            end
            // Carrier phase restarts on entry to each mark so the mark's first clock is high.
            if (w_next_mark && (w_next != r_state))
                r_car <= '0;
            else
                r_car <= (r_car == CAR_W'(CAR_PER - 1)) ? '0 : r_car + 1'b1;
            r_env  <= w_mark;
            r_out  <= w_mark && (r_car < CAR_W'(CAR_HIGH));
            r_busy <= (r_state != IDLE);
            r_done <= (r_state == IDLE) && r_busy;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign ir_env   = r_env;
    assign ir_out   = r_out;
endmodule
